// File: rtl/alu_prep_pipe.sv
// alu_prep_pipe: two-stage ALU operand preprocess + add with NZCV flags.
// Stage 1 decodes Op into (AMod, BMod, cin); stage 2 adds and registers
// the result and flags. Valid/ready handshake with backpressure, 2 slots.
module alu_prep_pipe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [2:0]   Op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] R,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_v
);

    localparam logic [2:0] OP_PASS_A = 3'b000;
    localparam logic [2:0] OP_NEG_A  = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_INC_A  = 3'b011;
    localparam logic [2:0] OP_SUB    = 3'b100;
    localparam logic [2:0] OP_DEC_A  = 3'b101;
    localparam logic [2:0] OP_PASS_B = 3'b110;
    localparam logic [2:0] OP_NOT_A  = 3'b111;

    // stage 1 state
    logic         r_s1_valid;
    logic [W-1:0] r_amod;
    logic [W-1:0] r_bmod;
    logic         r_cin;

    // stage 2 state (drives the outputs directly)
    logic         r_s2_valid;
    logic [W-1:0] r_res;
    logic         r_n, r_z, r_c, r_v;

    logic [W-1:0] w_amod;
    logic [W-1:0] w_bmod;
    logic         w_cin;
    logic         w_s1_adv;
    logic         w_s2_adv;
    logic [W:0]   w_sum;
    logic [W-1:0] w_res;
    logic         w_v;

    // A stage may move when it is empty or the stage after it is moving.
    // in_ready depends only on state and out_ready, never on in_valid.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // Op decode: every code maps to a defined operand triple, zeros otherwise
    always_comb begin
        w_amod = '0;
        w_bmod = '0;
        w_cin  = 1'b0;
        case (Op)
            OP_PASS_A: w_bmod = A;
            OP_NEG_A:  begin w_bmod = ~A; w_cin = 1'b1; end
            OP_ADD:    begin w_amod = A; w_bmod = B; end
            OP_INC_A:  begin w_amod = A; w_cin = 1'b1; end
            OP_SUB:    begin w_amod = A; w_bmod = ~B; w_cin = 1'b1; end
            OP_DEC_A:  begin w_amod = A; w_bmod = '1; end
            OP_PASS_B: w_bmod = B;
            OP_NOT_A:  w_bmod = ~A;
            default:   ;
        endcase
    end

    // W+1 bit add so the carry out falls into the top bit
    assign w_sum = {1'b0, r_amod} + {1'b0, r_bmod} + {{W{1'b0}}, r_cin};
    assign w_res = w_sum[W-1:0];
    assign w_v   = (r_amod[W-1] == r_bmod[W-1]) && (w_res[W-1] != r_amod[W-1]);

    // Stage 1: load on an input transfer, otherwise empty out when advancing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_amod     <= '0;
            r_bmod     <= '0;
            r_cin      <= 1'b0;
        end else if (in_valid && w_s1_adv) begin
            r_s1_valid <= 1'b1;
            r_amod     <= w_amod;
            r_bmod     <= w_bmod;
            r_cin      <= w_cin;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: capture sum and flags; hold them while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
            r_n        <= 1'b0;
            r_z        <= 1'b0;
            r_c        <= 1'b0;
            r_v        <= 1'b0;
        end else if (w_s2_adv && r_s1_valid) begin
            r_s2_valid <= 1'b1;
            r_res      <= w_res;
            r_n        <= w_res[W-1];
            r_z        <= (w_res == '0);
            r_c        <= w_sum[W];
            r_v        <= w_v;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign R         = r_res;
    assign flag_n    = r_n;
    assign flag_z    = r_z;
    assign flag_c    = r_c;
    assign flag_v    = r_v;

endmodule

// File: tb/tb_alu_prep_pipe.sv
// Bench for alu_prep_pipe: directed vector table, backpressure, full-rate
// random traffic against an arithmetic reference model, reset mid-stream,
// and W=4 / W=16 wrap checks.
module tb_alu_prep_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // W=8 instance
    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic       in_ready, out_valid;
    logic [7:0] A = '0, B = '0, R;
    logic [2:0] Op = '0;
    logic       fn, fz, fc, fv;

    alu_prep_pipe #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Op(Op), .out_valid(out_valid), .out_ready(out_ready),
        .R(R), .flag_n(fn), .flag_z(fz), .flag_c(fc), .flag_v(fv));

    // W=4 instance
    logic       v4_in = 1'b0, v4_ir, v4_ov;
    logic [3:0] a4 = '0, b4 = '0, r4;
    logic [2:0] op4 = '0;
    logic       n4, z4, c4, vv4;

    alu_prep_pipe #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4_in), .in_ready(v4_ir),
        .A(a4), .B(b4), .Op(op4), .out_valid(v4_ov), .out_ready(1'b1),
        .R(r4), .flag_n(n4), .flag_z(z4), .flag_c(c4), .flag_v(vv4));

    // W=16 instance
    logic        v16_in = 1'b0, v16_ir, v16_ov;
    logic [15:0] a16 = '0, b16 = '0, r16;
    logic [2:0]  op16 = '0;
    logic        n16, z16, c16, vv16;

    alu_prep_pipe #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16_in), .in_ready(v16_ir),
        .A(a16), .B(b16), .Op(op16), .out_valid(v16_ov), .out_ready(1'b1),
        .R(r16), .flag_n(n16), .flag_z(z16), .flag_c(c16), .flag_v(vv16));

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    logic [11:0] exp_q[$];
    logic [11:0] sb_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact unsigned and signed results of the operation,
    // reduced mod 256; V is "signed result out of range".
    function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, u, s;
        logic c, v;
        logic [7:0] r;
        ua = int'(a); ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        case (op)
            3'd0:    begin u = ua;       s = sa;       c = 1'b0; end
            3'd1:    begin u = -ua;      s = -sa;      c = (ua == 0); end
            3'd2:    begin u = ua + ub;  s = sa + sb;  c = (ua + ub > 255); end
            3'd3:    begin u = ua + 1;   s = sa + 1;   c = (ua == 255); end
            3'd4:    begin u = ua - ub;  s = sa - sb;  c = (ua >= ub); end
            3'd5:    begin u = ua - 1;   s = sa - 1;   c = (ua != 0); end
            3'd6:    begin u = ub;       s = sb;       c = 1'b0; end
            default: begin u = 255 - ua; s = -sa - 1;  c = 1'b0; end
        endcase
        r = 8'(u & 255);
        v = (s < -128) || (s > 127);
        return {r, r[7], (r == 8'h00), c, v};
    endfunction

    // Scoreboard: decide transfers mid-cycle, where all handshake signals are settled
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back(model(Op, A, B));
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_output: got R=%0h with no pending item", R);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_result", {R, fn, fz, fc, fv}, sb_e);
                end
            end
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b, r;
        logic       n, z, c, v;
    } vec_t;

    vec_t tbl[12];

    // One isolated op with out_ready high: checks acceptance, 2-cycle latency and result
    task automatic send_one(input string name, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [11:0] exp);
        @(posedge clk); #1;
        Op = op; A = a; B = b; in_valid = 1'b1;
        chk({name, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, "_lat1_out_valid"}, out_valid, 0);
        @(posedge clk); #1;
        chk({name, "_lat2_out_valid"}, out_valid, 1);
        chk(name, {R, fn, fz, fc, fv}, exp);
    endtask

    initial begin
        bit ir_exp[7];
        logic [11:0] held;
        int idx, got, base;

        //                 op     a      b      r      n  z  c  v
        tbl[0]  = '{3'b010, 8'h7F, 8'h01, 8'h80, 1, 0, 0, 1};
        tbl[1]  = '{3'b100, 8'h05, 8'h07, 8'hFE, 1, 0, 0, 0};
        tbl[2]  = '{3'b100, 8'h07, 8'h05, 8'h02, 0, 0, 1, 0};
        tbl[3]  = '{3'b001, 8'h00, 8'h5A, 8'h00, 0, 1, 1, 0};
        tbl[4]  = '{3'b001, 8'h80, 8'h00, 8'h80, 1, 0, 0, 1};
        tbl[5]  = '{3'b011, 8'hFF, 8'h33, 8'h00, 0, 1, 1, 0};
        tbl[6]  = '{3'b101, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 0};
        tbl[7]  = '{3'b110, 8'h99, 8'h3C, 8'h3C, 0, 0, 0, 0};
        tbl[8]  = '{3'b111, 8'h0F, 8'hAA, 8'hF0, 1, 0, 0, 0};
        tbl[9]  = '{3'b000, 8'hA5, 8'h11, 8'hA5, 1, 0, 0, 0};
        tbl[10] = '{3'b011, 8'h7F, 8'h00, 8'h80, 1, 0, 0, 1};
        tbl[11] = '{3'b101, 8'h80, 8'h00, 8'h7F, 0, 0, 1, 1};

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_R", {R, fn, fz, fc, fv}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #3 rst_n = 1'b1;

        // directed vectors
        for (int i = 0; i < 12; i++)
            send_one($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                     {tbl[i].r, tbl[i].n, tbl[i].z, tbl[i].c, tbl[i].v});

        // backpressure: 5 ADDs, consumer stalled for the first 4 cycles
        ir_exp = '{1, 1, 0, 0, 1, 1, 1};
        idx = 0; got = 0; held = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 4);
            in_valid  = (idx < 5);
            Op = 3'b010; A = 8'(idx + 1); B = 8'h10;
            @(negedge clk);
            if (cyc < 7) chk($sformatf("bp_in_ready_c%0d", cyc), in_ready, ir_exp[cyc]);
            chk($sformatf("bp_out_valid_c%0d", cyc), out_valid, (cyc >= 2 && cyc <= 8));
            if (cyc == 2) held = {R, fn, fz, fc, fv};
            if (cyc == 3) chk("bp_hold", {R, fn, fz, fc, fv}, held);
            if (out_valid && out_ready) begin
                chk($sformatf("bp_order%0d", got), R, 8'(8'h11 + got));
                got++;
            end
            if (in_valid && in_ready) idx++;
        end
        chk("bp_count", got, 5);
        in_valid = 1'b0;

        // full rate random traffic
        out_ready = 1'b1;
        base = n_out;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            Op = 3'($urandom_range(0, 7)); A = 8'($urandom); B = 8'($urandom);
            @(negedge clk);
            chk("fr_in_ready", in_ready, 1);
            if (i >= 2) chk("fr_out_valid", out_valid, 1);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("fr_out_count", n_out - base, 16);
        chk("fr_drained", exp_q.size(), 0);

        // reset with two items in flight
        @(posedge clk); #1;
        Op = 3'b010; A = 8'h01; B = 8'h02; in_valid = 1'b1;
        @(posedge clk); #1;
        A = 8'h03; B = 8'h04;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst2_pre_out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_R_flags", {R, fn, fz, fc, fv}, 0);
        chk("rst2_in_ready", in_ready, 1);
        @(posedge clk); #3 rst_n = 1'b1;
        send_one("post_rst", 3'b010, 8'h20, 8'h22, {8'h42, 1'b0, 1'b0, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        #1 chk("post_rst_drained", exp_q.size(), 0);

        // W=4 and W=16: ADD at max + 1 wraps to zero with carry
        @(posedge clk); #1;
        v4_in = 1'b1; op4 = 3'b010; a4 = 4'hF; b4 = 4'h1;
        v16_in = 1'b1; op16 = 3'b010; a16 = 16'hFFFF; b16 = 16'h0001;
        chk("w4_in_ready", v4_ir, 1);
        chk("w16_in_ready", v16_ir, 1);
        @(posedge clk); #1;
        v4_in = 1'b0; v16_in = 1'b0;
        @(posedge clk); #1;
        chk("w4_out_valid", v4_ov, 1);
        chk("w4_result", {r4, n4, z4, c4, vv4}, {4'h0, 1'b0, 1'b1, 1'b1, 1'b0});
        chk("w16_out_valid", v16_ov, 1);
        chk("w16_result", {r16, n16, z16, c16, vv16}, {16'h0000, 1'b0, 1'b1, 1'b1, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
